// File: rtl/up_arb_pkg.sv
// Shared constants for the up_* register-port arbiter.
package up_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [31:0] UP_TIMEOUT_DATA = 32'hdeaddead;
  localparam int          CNT_W           = 8;

endpackage

// File: rtl/up_arb_rr.sv
// Combinational round-robin selector: first requester after last_i, wrapping.
module up_arb_rr #(
  parameter int NUM_REQ = 2,
  parameter int GW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GW-1:0]      last_i,
  output logic [GW-1:0]      grant_o,
  output logic               any_o
);

  // Walk the distance from farthest to nearest so the nearest hit wins.
  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (req_i[j] && (j == (int'(last_i) + k) % NUM_REQ)) begin
          grant_o = GW'(j);
          any_o   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/up_arb.sv
// Round-robin arbiter sharing one up_* register port between NUM_REQ requesters.
module up_arb
  import up_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 14,
  parameter int TIMEOUT    = 16
) (
  input  logic                          up_clk,
  input  logic                          up_rst,
  input  logic [NUM_REQ-1:0]            s_wreq,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_waddr,
  input  logic [NUM_REQ*32-1:0]         s_wdata,
  output logic [NUM_REQ-1:0]            s_wack,
  input  logic [NUM_REQ-1:0]            s_rreq,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_raddr,
  output logic [31:0]                   s_rdata,
  output logic [NUM_REQ-1:0]            s_rack,
  output logic                          m_wreq,
  output logic                          m_rreq,
  output logic [ADDR_WIDTH-1:0]         m_waddr,
  output logic [ADDR_WIDTH-1:0]         m_raddr,
  output logic [31:0]                   m_wdata,
  input  logic                          m_wack,
  input  logic                          m_rack,
  input  logic [31:0]                   m_rdata,
  output logic                          timeout
);

  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                 pend_w_q, pend_r_q;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] waddr_q, raddr_q;
  logic [NUM_REQ-1:0][31:0]           wdata_q;

  logic [1:0]            state_q, state_d;
  logic [GW-1:0]         gnt_q, gnt_d, last_q, last_d;
  logic                  op_wr_q, op_wr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  to_q, to_d;
  logic [ADDR_WIDTH-1:0] m_waddr_q, m_waddr_d, m_raddr_q, m_raddr_d;
  logic [31:0]           m_wdata_q, m_wdata_d;

  logic [GW-1:0]         rr_gnt;
  logic                  rr_any;
  logic [NUM_REQ-1:0]    gnt_oh, wack, rack;
  logic                  ack_match;

  up_arb_rr #(.NUM_REQ(NUM_REQ), .GW(GW)) u_rr (
    .req_i   (pend_w_q | pend_r_q),
    .last_i  (last_q),
    .grant_o (rr_gnt),
    .any_o   (rr_any)
  );

  assign gnt_oh    = NUM_REQ'(1) << gnt_q;
  assign wack      = (state_q == ST_RESP &&  op_wr_q) ? gnt_oh : '0;
  assign rack      = (state_q == ST_RESP && !op_wr_q) ? gnt_oh : '0;
  assign ack_match = op_wr_q ? m_wack : m_rack;

  assign s_wack  = wack;
  assign s_rack  = rack;
  assign s_rdata = (state_q == ST_RESP && !op_wr_q) ? rdata_q : '0;
  assign timeout = (state_q == ST_RESP) && to_q;
  assign m_wreq  = (state_q == ST_ISSUE) &&  op_wr_q;
  assign m_rreq  = (state_q == ST_ISSUE) && !op_wr_q;
  assign m_waddr = m_waddr_q;
  assign m_raddr = m_raddr_q;
  assign m_wdata = m_wdata_q;

  // A pulse loads an empty slot, or one being cleared this cycle; otherwise it is dropped.
  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      pend_w_q <= '0;
      pend_r_q <= '0;
      waddr_q  <= '0;
      raddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (s_wreq[i] && (!pend_w_q[i] || wack[i])) begin
          pend_w_q[i] <= 1'b1;
          waddr_q[i]  <= s_waddr[i*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_q[i]  <= s_wdata[i*32 +: 32];
        end else if (wack[i]) begin
          pend_w_q[i] <= 1'b0;
        end
        if (s_rreq[i] && (!pend_r_q[i] || rack[i])) begin
          pend_r_q[i] <= 1'b1;
          raddr_q[i]  <= s_raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end else if (rack[i]) begin
          pend_r_q[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    op_wr_d   = op_wr_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    to_d      = to_q;
    m_waddr_d = m_waddr_q;
    m_raddr_d = m_raddr_q;
    m_wdata_d = m_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (rr_any) begin
          gnt_d   = rr_gnt;
          op_wr_d = pend_w_q[rr_gnt];
          cnt_d   = '0;
          to_d    = 1'b0;
          if (pend_w_q[rr_gnt]) begin
            m_waddr_d = waddr_q[rr_gnt];
            m_wdata_d = wdata_q[rr_gnt];
          end else begin
            m_raddr_d = raddr_q[rr_gnt];
          end
          state_d = ST_ISSUE;
        end
      end
      // Counter is 0 in the request cycle, so it reads k in cycle m_req+k.
      ST_ISSUE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (ack_match) begin
          rdata_d = m_rdata;
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (ack_match) begin
          rdata_d = m_rdata;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdata_d = UP_TIMEOUT_DATA;
          to_d    = 1'b1;
          state_d = ST_RESP;
        end
      end
      default: begin
        last_d  = gnt_q;
        to_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      last_q    <= GW'(NUM_REQ - 1);
      op_wr_q   <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      to_q      <= 1'b0;
      m_waddr_q <= '0;
      m_raddr_q <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      op_wr_q   <= op_wr_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      to_q      <= to_d;
      m_waddr_q <= m_waddr_d;
      m_raddr_q <= m_raddr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

endmodule

// File: tb/tb_up_arb.sv
// Scoreboard bench for up_arb: directed requests, monitor checks master issues and slave acks.
module tb_up_arb;

  localparam int NR = 2;
  localparam int AW = 14;
  localparam int TO = 16;

  logic                up_clk = 1'b0;
  logic                up_rst;
  logic [NR-1:0]       s_wreq, s_rreq, s_wack, s_rack;
  logic [NR*AW-1:0]    s_waddr, s_raddr;
  logic [NR*32-1:0]    s_wdata;
  logic [31:0]         s_rdata, m_wdata;
  logic [31:0]         m_rdata = 32'h0;
  logic                m_wreq, m_rreq, timeout;
  logic                m_wack = 1'b0;
  logic                m_rack = 1'b0;
  logic [AW-1:0]       m_waddr, m_raddr;

  typedef struct {
    bit          wr;
    int          idx;
    logic [AW-1:0] addr;
    logic [31:0] data;
    bit          to;
    int          cyc;
  } ex_t;

  ex_t mq[$];
  ex_t sq[$];
  int  cyc = 0;
  int  nvec = 0;
  int  nerr = 0;
  int  inj_cyc = -1;
  bit  per_en = 1'b1;
  bit  go_w = 1'b0;
  bit  go_r = 1'b0;
  logic [31:0] per_rdata = 32'hA;

  up_arb #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .up_clk  (up_clk),
    .up_rst  (up_rst),
    .s_wreq  (s_wreq),
    .s_waddr (s_waddr),
    .s_wdata (s_wdata),
    .s_wack  (s_wack),
    .s_rreq  (s_rreq),
    .s_raddr (s_raddr),
    .s_rdata (s_rdata),
    .s_rack  (s_rack),
    .m_wreq  (m_wreq),
    .m_rreq  (m_rreq),
    .m_waddr (m_waddr),
    .m_raddr (m_raddr),
    .m_wdata (m_wdata),
    .m_wack  (m_wack),
    .m_rack  (m_rack),
    .m_rdata (m_rdata),
    .timeout (timeout)
  );

  always #5 up_clk = ~up_clk;
  always @(posedge up_clk) cyc <= cyc + 1;

  // Peripheral: acks in the cycle after a request, when enabled; inj_cyc forces a stray read ack.
  always @(negedge up_clk) begin
    go_w = per_en && (m_wreq === 1'b1);
    go_r = per_en && (m_rreq === 1'b1);
  end
  always @(posedge up_clk) begin
    #1;
    m_wack  = go_w;
    m_rack  = go_r || (cyc == inj_cyc);
    m_rdata = m_rack ? per_rdata : 32'h5a5a5a5a;
    go_w    = 1'b0;
    go_r    = 1'b0;
  end

  always @(negedge up_clk) begin
    ex_t e;
    logic [NR-1:0] xa, ga, oa;
    if (m_wreq === 1'b1 || m_rreq === 1'b1) begin
      nvec++;
      if (mq.size() == 0) begin
        nerr++;
        $display("FAIL m_req unexpected at cyc %0d: wreq=%b rreq=%b", cyc, m_wreq, m_rreq);
      end else begin
        e = mq.pop_front();
        if (m_wreq !== e.wr || m_rreq !== !e.wr || cyc != e.cyc ||
            (e.wr ? (m_waddr !== e.addr || m_wdata !== e.data) : (m_raddr !== e.addr))) begin
          nerr++;
          $display("FAIL m_req got wr=%b waddr=%h wdata=%h raddr=%h cyc=%0d, want wr=%b addr=%h data=%h cyc=%0d",
                   m_wreq, m_waddr, m_wdata, m_raddr, cyc, e.wr, e.addr, e.data, e.cyc);
        end
      end
    end
    if (s_wack !== '0 || s_rack !== '0) begin
      nvec++;
      if (sq.size() == 0) begin
        nerr++;
        $display("FAIL s_ack unexpected at cyc %0d: wack=%b rack=%b", cyc, s_wack, s_rack);
      end else begin
        e  = sq.pop_front();
        xa = NR'(1) << e.idx;
        ga = e.wr ? s_wack : s_rack;
        oa = e.wr ? s_rack : s_wack;
        if (ga !== xa || oa !== '0 || timeout !== e.to || cyc != e.cyc ||
            (!e.wr && s_rdata !== e.data)) begin
          nerr++;
          $display("FAIL s_ack got wack=%b rack=%b rdata=%h to=%b cyc=%0d, want wr=%b req=%0d rdata=%h to=%b cyc=%0d",
                   s_wack, s_rack, s_rdata, timeout, cyc, e.wr, e.idx, e.data, e.to, e.cyc);
        end
      end
    end else if (timeout !== 1'b0 || s_rdata !== 32'h0) begin
      nvec++;
      nerr++;
      $display("FAIL idle outputs at cyc %0d: timeout=%b s_rdata=%h, want 0 and 0", cyc, timeout, s_rdata);
    end
  end

  task automatic tick();
    @(posedge up_clk);
    #1;
    s_wreq = '0;
    s_rreq = '0;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((mq.size() != 0 || sq.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (mq.size() != 0 || sq.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL drain: %0d m_req and %0d s_ack still outstanding, want 0 and 0", mq.size(), sq.size());
      mq.delete();
      sq.delete();
    end
    tick();
    tick();
  endtask

  task automatic chk_zero(input string nm);
    nvec++;
    if (s_wack !== '0 || s_rack !== '0 || s_rdata !== '0 || m_wreq !== 1'b0 || m_rreq !== 1'b0 ||
        m_waddr !== '0 || m_raddr !== '0 || m_wdata !== '0 || timeout !== 1'b0) begin
      nerr++;
      $display("FAIL %s got wack=%b rack=%b rdata=%h wreq=%b rreq=%b waddr=%h raddr=%h wdata=%h to=%b, want all 0",
               nm, s_wack, s_rack, s_rdata, m_wreq, m_rreq, m_waddr, m_raddr, m_wdata, timeout);
    end
  endtask

  function automatic void exp_m(input bit wr, input logic [AW-1:0] a, input logic [31:0] d, input int c);
    ex_t e;
    e.wr = wr; e.idx = 0; e.addr = a; e.data = d; e.to = 1'b0; e.cyc = c;
    mq.push_back(e);
  endfunction

  function automatic void exp_s(input bit wr, input int idx, input logic [31:0] d, input bit to, input int c);
    ex_t e;
    e.wr = wr; e.idx = idx; e.addr = '0; e.data = d; e.to = to; e.cyc = c;
    sq.push_back(e);
  endfunction

  initial begin
    int c;
    up_rst  = 1'b1;
    s_wreq  = '0;
    s_rreq  = '0;
    s_waddr = '0;
    s_raddr = '0;
    s_wdata = '0;
    repeat (3) tick();
    chk_zero("reset_state");
    up_rst = 1'b0;
    tick();

    // Contention: both read at once, each re-requests the cycle after its ack.
    c = cyc;
    s_rreq = 2'b11;
    s_raddr[0 +: AW]  = 14'h020;
    s_raddr[AW +: AW] = 14'h030;
    exp_m(0, 14'h020, 32'h0, c + 2);  exp_s(0, 0, 32'hA, 0, c + 4);
    exp_m(0, 14'h030, 32'h0, c + 6);  exp_s(0, 1, 32'hA, 0, c + 8);
    exp_m(0, 14'h021, 32'h0, c + 10); exp_s(0, 0, 32'hA, 0, c + 12);
    exp_m(0, 14'h031, 32'h0, c + 14); exp_s(0, 1, 32'hA, 0, c + 16);
    tick();
    goto(c + 5);
    s_rreq[0] = 1'b1;
    s_raddr[0 +: AW] = 14'h021;
    tick();
    goto(c + 9);
    s_rreq[1] = 1'b1;
    s_raddr[AW +: AW] = 14'h031;
    tick();
    drain(40);

    // Single write, minimum latency.
    c = cyc;
    s_wreq[0] = 1'b1;
    s_waddr[0 +: AW] = 14'h010;
    s_wdata[0 +: 32] = 32'h12345678;
    exp_m(1, 14'h010, 32'h12345678, c + 2);
    exp_s(1, 0, 32'h0, 0, c + 4);
    tick();
    drain(20);

    // Silent peripheral on a read, then a normal read.
    per_en = 1'b0;
    c = cyc;
    s_rreq[1] = 1'b1;
    s_raddr[AW +: AW] = 14'h040;
    exp_m(0, 14'h040, 32'h0, c + 2);
    exp_s(0, 1, 32'hdeaddead, 1, c + 2 + TO);
    tick();
    drain(40);
    per_en = 1'b1;
    c = cyc;
    s_rreq[0] = 1'b1;
    s_raddr[0 +: AW] = 14'h050;
    exp_m(0, 14'h050, 32'h0, c + 2);
    exp_s(0, 0, 32'hA, 0, c + 4);
    tick();
    drain(20);

    // Write and read from one requester together, plus a duplicate write pulse.
    c = cyc;
    s_wreq[1] = 1'b1;
    s_rreq[1] = 1'b1;
    s_waddr[AW +: AW] = 14'h060;
    s_wdata[32 +: 32] = 32'h11111111;
    s_raddr[AW +: AW] = 14'h070;
    exp_m(1, 14'h060, 32'h11111111, c + 2); exp_s(1, 1, 32'h0, 0, c + 4);
    exp_m(0, 14'h070, 32'h0, c + 6);        exp_s(0, 1, 32'hA, 0, c + 8);
    tick();
    s_wreq[1] = 1'b1;
    s_waddr[AW +: AW] = 14'h061;
    s_wdata[32 +: 32] = 32'h22222222;
    tick();
    drain(30);

    // Reset during WAIT, then a late read ack, then a fresh write.
    per_en = 1'b0;
    c = cyc;
    s_rreq[0] = 1'b1;
    s_raddr[0 +: AW] = 14'h080;
    exp_m(0, 14'h080, 32'h0, c + 2);
    tick();
    goto(c + 4);
    up_rst = 1'b1;
    tick();
    up_rst = 1'b0;
    inj_cyc = c + 6;
    chk_zero("reset_mid_wait");
    goto(c + 8);
    chk_zero("late_ack_ignored");
    per_en = 1'b1;
    c = cyc;
    s_wreq[1] = 1'b1;
    s_waddr[AW +: AW] = 14'h090;
    s_wdata[32 +: 32] = 32'h33333333;
    exp_m(1, 14'h090, 32'h33333333, c + 2);
    exp_s(1, 1, 32'h0, 0, c + 4);
    tick();
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
